// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-producer register write-back arbiter with pending-write queue and forwarding
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [ADDR_W-1:0] in0_waddr,
    input  logic [DATA_W-1:0] in0_wdata,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [ADDR_W-1:0] in1_waddr,
    input  logic [DATA_W-1:0] in1_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] fwd_raddr1,
    input  logic [ADDR_W-1:0] fwd_raddr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              prio_q, prio_d;

    logic [CW:0] free;
    logic        need0, need1;
    logic        enq0, enq1, deq;
    logic        contention;

    // Slots available this cycle: the head always drains, so a non-empty queue frees one extra slot.
    assign free = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, (count_q != '0)};

    assign need0 = in0_valid && (in0_waddr != '0);
    assign need1 = in1_valid && (in1_waddr != '0);
    assign contention = (free == (CW+1)'(1)) && need0 && need1;

    // Ready from registered occupancy/priority and the current requests only; r0 writes never need a slot.
    always_comb begin
        in0_ready = (in0_waddr == '0) || (free >= (CW+1)'(2))
                 || ((free == (CW+1)'(1)) && (!need1 || !prio_q));
        in1_ready = (in1_waddr == '0) || (free >= (CW+1)'(2))
                 || ((free == (CW+1)'(1)) && (!need0 || prio_q));
    end

    assign enq0 = !rst && need0 && in0_ready;
    assign enq1 = !rst && need1 && in1_ready;
    assign deq  = (count_q != '0);

    // Write port presents the head entry straight from registered state.
    always_comb begin
        we    = deq;
        waddr = deq ? addr_q[rd_ptr_q] : '0;
        wdata = deq ? data_q[rd_ptr_q] : '0;
    end

    // Youngest matching entry wins: scan oldest to youngest, later matches override.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] ra);
        logic [DATA_W:0] res;
        logic [PW-1:0]   idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (ra != '0) && (addr_q[idx] == ra))
                res = {1'b1, data_q[idx]};
        end
        return res;
    endfunction

    // Forwarding lookups against the registered queue contents only.
    always_comb begin
        {fwd_hit1, fwd_data1} = lookup(fwd_raddr1);
        {fwd_hit2, fwd_data2} = lookup(fwd_raddr2);
    end

    // Next-state for pointers, occupancy and round-robin priority.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(deq);
        wr_ptr_d = wr_ptr_q + PW'(enq0) + PW'(enq1);
        count_d  = count_q + CW'(enq0) + CW'(enq1) - CW'(deq);
        prio_d   = (!rst && contention) ? !prio_q : prio_q;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
        end
    end

    // Queue storage; in0 lands ahead of in1 when both enqueue together.
    always_ff @(posedge clk) begin
        if (enq0) begin
            addr_q[wr_ptr_q] <= in0_waddr;
            data_q[wr_ptr_q] <= in0_wdata;
        end
        if (enq1) begin
            addr_q[wr_ptr_q + PW'(enq0)] <= in1_waddr;
            data_q[wr_ptr_q + PW'(enq0)] <= in1_wdata;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue reference model
module tb_wb_arbiter;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in0_valid, in0_ready;
    logic [ADDR_W-1:0] in0_waddr;
    logic [DATA_W-1:0] in0_wdata;
    logic              in1_valid, in1_ready;
    logic [ADDR_W-1:0] in1_waddr;
    logic [DATA_W-1:0] in1_wdata;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] fwd_raddr1, fwd_raddr2;
    logic              fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;

    int n_cmp = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] qa [$];
    logic [DATA_W-1:0] qd [$];
    bit                mprio;
    bit                chk_out;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_waddr(in0_waddr), .in0_wdata(in0_wdata),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_waddr(in1_waddr), .in1_wdata(in1_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_free();
        int n = qa.size();
        return DEPTH - n + ((n != 0) ? 1 : 0);
    endfunction

    // Expected ready for a port holding a valid request, from the slot rules.
    function automatic bit model_ready(input logic [ADDR_W-1:0] a_me, input bit need_other, input bit me_is_in1);
        int f = model_free();
        if (a_me == '0) return 1'b1;
        if (f >= 2) return 1'b1;
        if (f == 0) return 1'b0;
        if (!need_other) return 1'b1;
        return (mprio == me_is_in1);
    endfunction

    function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] ra);
        if (ra == '0) return '0;
        for (int i = qa.size() - 1; i >= 0; i--)
            if (qa[i] == ra) return {1'b1, qd[i]};
        return '0;
    endfunction

    task automatic cyc(input bit r,
                       input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic [ADDR_W-1:0] f1, input logic [ADDR_W-1:0] f2);
        bit n0, n1, e0, e1, cont;
        logic [DATA_W:0] x1, x2;
        rst = r;
        in0_valid = v0; in0_waddr = a0; in0_wdata = d0;
        in1_valid = v1; in1_waddr = a1; in1_wdata = d1;
        fwd_raddr1 = f1; fwd_raddr2 = f2;
        #1;
        n0 = v0 && (a0 != '0);
        n1 = v1 && (a1 != '0);
        e0 = model_ready(a0, n1, 1'b0);
        e1 = model_ready(a1, n0, 1'b1);
        cont = (model_free() == 1) && n0 && n1;
        if (!r && v0) chk("in0_ready", in0_ready, e0);
        if (!r && v1) chk("in1_ready", in1_ready, e1);
        if (chk_out) begin
            x1 = model_fwd(f1);
            x2 = model_fwd(f2);
            chk("we", we, (qa.size() != 0));
            chk("waddr", waddr, ((qa.size() != 0) ? qa[0] : '0));
            chk("wdata", wdata, ((qd.size() != 0) ? qd[0] : '0));
            chk("fwd_hit1", fwd_hit1, x1[DATA_W]);
            chk("fwd_data1", fwd_data1, x1[DATA_W-1:0]);
            chk("fwd_hit2", fwd_hit2, x2[DATA_W]);
            chk("fwd_data2", fwd_data2, x2[DATA_W-1:0]);
        end
        @(posedge clk);
        if (r) begin
            qa.delete(); qd.delete();
            mprio = 1'b0;
            chk_out = 1'b1;
        end else begin
            if (cont) mprio = !mprio;
            if (qa.size() != 0) begin
                void'(qa.pop_front()); void'(qd.pop_front());
            end
            if (n0 && e0) begin qa.push_back(a0); qd.push_back(d0); end
            if (n1 && e1) begin qa.push_back(a1); qd.push_back(d1); end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [ADDR_W-1:0] f1, input logic [ADDR_W-1:0] f2);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, f1, f2);
    endtask

    initial begin
        chk_out = 1'b0;
        mprio = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);
        cyc(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);
        chk("reset_we", we, 1'b0);
        chk("reset_waddr", waddr, 5'd0);
        chk("reset_wdata", wdata, 32'h0);
        chk("reset_hit1", fwd_hit1, 1'b0);
        chk("reset_data1", fwd_data1, 32'h0);

        // single write
        cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 5'd3, 5'd0);
        chk("single_we", we, 1'b1);
        chk("single_waddr", waddr, 5'd3);
        chk("single_wdata", wdata, 32'h11);
        idle(5'd3, 5'd0);
        chk("single_we_after", we, 1'b0);

        // dual accept to the same register
        cyc(1'b0, 1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB, 5'd5, 5'd0);
        chk("dual_waddr", waddr, 5'd5);
        chk("dual_wdata_first", wdata, 32'hA);
        chk("dual_fwd_hit", fwd_hit1, 1'b1);
        chk("dual_fwd_data", fwd_data1, 32'hB);
        idle(5'd5, 5'd0);
        chk("dual_wdata_second", wdata, 32'hB);
        idle(5'd5, 5'd0);

        // fill and backpressure: expect accepts in0+in1 x3, then in0, in1, in0
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                in0_valid = 1'b1; in0_waddr = 5'd9; in1_valid = 1'b1; in1_waddr = 5'd10; #1;
                chk("fill_grant0_in0", in0_ready, 1'b1);
                chk("fill_grant0_in1", in1_ready, 1'b0);
            end
            cyc(1'b0, 1'b1, 5'(1 + 2 * i), 32'h100 + i, 1'b1, 5'(2 + 2 * i), 32'h200 + i,
                5'(1 + 2 * i), 5'(2 + 2 * i));
        end
        chk("fill_full_count", qa.size(), 4);

        // r0 discard while full
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 5'd1, 5'd0);
        chk("r0_hit2", fwd_hit2, 1'b0);

        // drain four pending writes
        for (int i = 0; i < 4; i++) idle(qa.size() != 0 ? qa[0] : 5'd0, 5'd0);
        chk("drain_we_off", we, 1'b0);

        // reset mid-operation with three pending
        cyc(1'b0, 1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 5'd20, 5'd21);
        cyc(1'b0, 1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, 5'd22, 5'd23);
        chk("pre_reset_pending", qa.size(), 3);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd21, 5'd22);
        chk("mid_reset_we", we, 1'b0);
        chk("mid_reset_hit1", fwd_hit1, 1'b0);
        chk("mid_reset_hit2", fwd_hit2, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 5'(11 + i), 32'h300 + i, 1'b1, 5'(16 + i), 32'h400 + i, 5'd23, 5'd20);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 79) == 0),
                ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
